key_debounce: RTL and testbench

//  Debounces one mechanical push-button input for the board-level UI logic.
//  The raw key is asynchronous to clk, so it is synchronised first.
//  The output changes level only after the synchronised key has held a new

---
 rtl/key_debounce_pkg.sv | 13 +
 rtl/key_debounce_sync_ff.sv | 26 ++
 rtl/key_debounce.sv | 63 ++++++
 tb/tb_key_debounce.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Purpose: shared helpers for the key_debounce block.
// Contents: counter-width function used to size the stability counter.
// Used by: key_debounce (filter counter width).
package key_debounce_pkg;

    // Width needed to hold 0..stable, never less than one bit.
    function automatic int cnt_width(input int stable);
        int w;
        w = $clog2(stable + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debounce_sync_ff.sv
// Purpose: N-stage shift synchroniser for a single asynchronous bit.
// Ports: i_clk sampling clock, i_rst async active-high reset, i_d raw bit,
//        o_q synchronised bit (last stage); flops reset to RST_VAL.
module sync_ff #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_chain;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= {N{RST_VAL}};
        end else begin
            r_chain <= {r_chain[N-2:0], i_d};
        end
    end

    assign o_q = r_chain[N-1];

endmodule

// File: rtl/key_debounce.sv
// Purpose: debounce one mechanical push-button sampled on a slow clock.
// Ports: clk sampling clock, rst_n async reset (active HIGH despite the name),
//        key raw level, key_debounced registered level after the stability filter.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 2,
    parameter logic IDLE_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic key_debounced
);

    localparam int               CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             w_key_s;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_out;
    logic             w_out_nxt;

    sync_ff #(
        .N       (SYNC_STAGES),
        .RST_VAL (IDLE_LEVEL)
    ) u_sync (
        .i_clk (clk),
        .i_rst (rst_n),
        .i_d   (key),
        .o_q   (w_key_s)
    );

    // Count consecutive samples that disagree with the output; any agreeing
    // sample restarts the count, so a bounce train never accumulates.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_out_nxt = r_out;
        if (w_key_s == r_out) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == CNT_MAX) begin
            w_out_nxt = w_key_s;
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_cnt <= '0;
            r_out <= IDLE_LEVEL;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_out <= w_out_nxt;
        end
    end

    assign key_debounced = r_out;

endmodule

// File: tb/tb_key_debounce.sv
`timescale 1ms/1us
module tb_key_debounce;

    localparam int LAT  = 3;   // 2 sync stages + 2 stable cycles - 1
    localparam int LAT4 = 5;   // 2 sync stages + 4 stable cycles - 1

    typedef struct {
        int   edge_idx;
        logic val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key = 1'b0;
    logic key4 = 1'b0;
    logic dbo;
    logic dbo4;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int n_rise = 0;
    int n_fall = 0;

    exp_t exp_q[$];
    exp_t exp4_q[$];
    bit   mon_en = 1'b1;
    logic mon_prev = 1'b0;
    logic mon4_prev = 1'b0;

    key_debounce dut (
        .clk           (clk),
        .rst_n         (rst),
        .key           (key),
        .key_debounced (dbo)
    );

    key_debounce #(.STABLE_CYCLES(4)) dut4 (
        .clk           (clk),
        .rst_n         (rst),
        .key           (key4),
        .key_debounced (dbo4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n = edge_n + 1;

    // Scoreboard monitor for the default instance: every output transition
    // must match the oldest pending expectation in edge index and level.
    always @(posedge clk) begin
        exp_t e;
        #0.1;
        if (mon_en && dbo !== mon_prev) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_transition: got %b at edge %0d, expected no change", dbo, edge_n);
            end else begin
                e = exp_q.pop_front();
                if (dbo !== e.val || edge_n !== e.edge_idx) begin
                    errors = errors + 1;
                    $display("FAIL transition: got %b at edge %0d, expected %b at edge %0d",
                             dbo, edge_n, e.val, e.edge_idx);
                end
            end
            if (dbo === 1'b1) n_rise = n_rise + 1;
            else              n_fall = n_fall + 1;
            mon_prev = dbo;
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #0.1;
        if (dbo4 !== mon4_prev) begin
            checks = checks + 1;
            if (exp4_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_transition_sc4: got %b at edge %0d, expected no change", dbo4, edge_n);
            end else begin
                e = exp4_q.pop_front();
                if (dbo4 !== e.val || edge_n !== e.edge_idx) begin
                    errors = errors + 1;
                    $display("FAIL transition_sc4: got %b at edge %0d, expected %b at edge %0d",
                             dbo4, edge_n, e.val, e.edge_idx);
                end
            end
            mon4_prev = dbo4;
        end
    end

    // Key changes are always made between clock edges, so the first edge
    // sampling the new level is the next one (edge_n + 1).
    task automatic set_key(input logic v);
        key = v;
        exp_q.push_back('{edge_n + 1 + LAT, v});
    endtask

    task automatic set_key4(input logic v);
        key4 = v;
        exp4_q.push_back('{edge_n + 1 + LAT4, v});
    endtask

    task automatic align;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        // Reset asserted from time 0, key toggling before release.
        for (int i = 0; i < 4; i++) begin
            #0.5;
            key = ~key;
            checks = checks + 1;
            if (dbo !== 1'b0 || dut.r_cnt !== '0) begin
                errors = errors + 1;
                $display("FAIL reset_initial: got out=%b cnt=%0d, expected out=0 cnt=0", dbo, dut.r_cnt);
            end
        end
        key = 1'b0;
        #0.5;
        rst = 1'b0;   // released at 2.5 ms
    endtask

    task automatic test_reset_hold;
        // Reset held across several edges while the key toggles.
        align();
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            #1.3;
            key = ~key;
            if (i % 6 == 0) begin
                checks = checks + 1;
                if (dbo !== 1'b0 || dut.r_cnt !== '0) begin
                    errors = errors + 1;
                    $display("FAIL reset_hold: got out=%b cnt=%0d, expected out=0 cnt=0", dbo, dut.r_cnt);
                end
            end
        end
        key = 1'b0;
        align();
        rst = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_bounce;
        n_rise = 0;
        n_fall = 0;
        for (int it = 0; it < 10; it++) begin
            align();
            for (int t = 0; t < 12; t++) begin
                key = ~key;
                #0.35;
            end
            set_key(1'b1);          // 13th toggle, ends high
            #30.6;
            set_key(1'b0);
            #50.6;
        end
        repeat (5) @(posedge clk);
        checks = checks + 1;
        if (n_rise !== 10 || n_fall !== 10) begin
            errors = errors + 1;
            $display("FAIL bounce_count: got rise=%0d fall=%0d, expected rise=10 fall=10", n_rise, n_fall);
        end
    endtask

    task automatic test_glitch;
        align();
        key = 1'b1;     // 3 ms pulse between two edges
        #3;
        key = 1'b0;
        #4;             // now at edge+8
        key = 1'b1;     // 3 ms pulse straddling one edge
        #3;
        key = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks = checks + 1;
        if (dbo !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL glitch: got %b, expected 0", dbo);
        end
    endtask

    task automatic test_long_press;
        align();
        set_key(1'b1);
        #100;
        checks = checks + 1;
        if (dbo !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL long_press_mid: got %b, expected 1", dbo);
        end
        #100;
        set_key(1'b0);
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset_mid_press;
        align();
        set_key(1'b1);
        repeat (5) @(posedge clk);
        #3;
        checks = checks + 1;
        if (dbo !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL mid_press_before: got %b, expected 1", dbo);
        end
        mon_en = 1'b0;
        rst = 1'b1;
        #0.1;
        checks = checks + 1;
        if (dbo !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL mid_press_async: got %b, expected 0", dbo);
        end
        #2;
        // Synchroniser was cleared, so the held key is re-acquired from scratch.
        exp_q.push_back('{edge_n + 1 + LAT, 1'b1});
        mon_prev = 1'b0;
        mon_en = 1'b1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        set_key(1'b0);
        repeat (6) @(posedge clk);
    endtask

    task automatic test_stable4;
        align();
        set_key4(1'b1);
        #80;
        set_key4(1'b0);
        #80;
        align();
        #7;             // edge+8: pulse covers exactly three edges
        key4 = 1'b1;
        #23;
        key4 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks = checks + 1;
        if (dbo4 !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL sc4_reject: got %b, expected 0", dbo4);
        end
    endtask

    initial begin
        test_reset();
        repeat (3) @(posedge clk);
        test_bounce();
        test_glitch();
        test_long_press();
        test_reset_mid_press();
        test_stable4();
        test_reset_hold();
        checks = checks + 1;
        if (exp_q.size() != 0 || exp4_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL pending_expectations: got %0d/%0d outstanding, expected 0/0",
                     exp_q.size(), exp4_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
